ddc_phase_sched: RTL and testbench



---
 rtl/ddc_phase_sched.sv | 113 +++++++++++
 tb/tb_ddc_phase_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_phase_sched.sv
// ddc_phase_sched: double-buffered tone bank and frame scheduler producing 4-lane ddc_core phase words.
// Define DDC_SCHED_FRAME_CNT_EN to add the frame_cnt output.
module ddc_phase_sched #(
  parameter int N_CH = 4,
  parameter int PW = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [$clog2(N_CH)-1:0] cfg_addr,
  input  logic [PW-1:0]           cfg_pinc,
  input  logic [PW-1:0]           cfg_poff,
  input  logic                    cfg_commit,
  output logic                    cfg_ready,
  input  logic                    run_en,
  output logic [47:0]             phase_in_0,
  output logic [47:0]             phase_in_1,
  output logic [47:0]             phase_in_2,
  output logic [47:0]             phase_in_3,
  output logic                    phase_valid,
  output logic [$clog2(N_CH)-1:0] ch_index,
`ifdef DDC_SCHED_FRAME_CNT_EN
  output logic [31:0]             frame_cnt,
`endif
  output logic                    frame_start
);
  localparam int AW = $clog2(N_CH);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic pending, wrap, swap, addr_ok;
  logic [PW-1:0] sh_pinc [N_CH];
  logic [PW-1:0] sh_poff [N_CH];
  logic [PW-1:0] ac_pinc [N_CH];
  logic [PW-1:0] ac_poff [N_CH];
  logic [PW-1:0] inc4;
  logic [PW-1:0] off [4];
  assign cfg_ready = !pending;
  assign addr_ok = int'(cfg_addr) < N_CH;
  always_comb begin
    wrap = (state == RUN) && (cnt == AW'(N_CH - 1));
    swap = pending && ((state != RUN) || wrap);
    state_nx = (state == IDLE) ? (run_en ? LOAD : IDLE) :
               (state == LOAD) ? RUN :
               (wrap && !run_en) ? IDLE : RUN;
    cnt_nx = (state == RUN && !wrap) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pending <= swap ? 1'b0 : (cfg_commit ? 1'b1 : pending);
    end
  end
  // writes need !pending and swaps need pending, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_pinc <= '{default: '0};
      sh_poff <= '{default: '0};
      ac_pinc <= '{default: '0};
      ac_poff <= '{default: '0};
    end else begin
      if (cfg_wr && !pending && addr_ok) begin
        sh_pinc[cfg_addr] <= cfg_pinc;
        sh_poff[cfg_addr] <= cfg_poff;
      end
      if (swap) begin
        ac_pinc <= sh_pinc;
        ac_poff <= sh_poff;
      end
    end
  end
  always_comb begin
    inc4 = ac_pinc[cnt] << 2;
    off[0] = ac_poff[cnt];
    for (int k = 1; k < 4; k++) off[k] = off[k-1] + ac_pinc[cnt];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_in_0 <= '0;
      phase_in_1 <= '0;
      phase_in_2 <= '0;
      phase_in_3 <= '0;
      phase_valid <= 1'b0;
      ch_index <= '0;
      frame_start <= 1'b0;
    end else begin
      phase_in_0 <= {4'b0, off[0], 4'b0, inc4};
      phase_in_1 <= {4'b0, off[1], 4'b0, inc4};
      phase_in_2 <= {4'b0, off[2], 4'b0, inc4};
      phase_in_3 <= {4'b0, off[3], 4'b0, inc4};
      phase_valid <= state == RUN;
      ch_index <= cnt;
      frame_start <= (state == RUN) && (cnt == '0);
    end
  end
`ifdef DDC_SCHED_FRAME_CNT_EN
  logic [31:0] fc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc <= '0;
      frame_cnt <= '0;
    end else begin
      fc <= swap ? '0 : (wrap ? fc + 1'b1 : fc);
      frame_cnt <= fc;
    end
  end
`endif
endmodule

// File: tb/tb_ddc_phase_sched.sv
// tb_ddc_phase_sched: randomized scenarios checked against a bank-level model of ddc_phase_sched.
module tb_ddc_phase_sched;
  localparam int N = 4;
  localparam int AW = 2;
  logic clk = 0, rst = 1, cfg_wr = 0, cfg_commit = 0, run_en = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [19:0] cfg_pinc = '0, cfg_poff = '0;
  logic cfg_ready, phase_valid, frame_start;
  logic [47:0] phase_in_0, phase_in_1, phase_in_2, phase_in_3;
  logic [AW-1:0] ch_index;
`ifdef DDC_SCHED_FRAME_CNT_EN
  logic [31:0] frame_cnt;
`endif
  logic [47:0] lane [4];
  logic [19:0] sp [N];
  logic [19:0] so [N];
  logic [19:0] ap [N];
  logic [19:0] ao [N];
  int tests = 0, fails = 0;

  ddc_phase_sched #(.N_CH(N), .PW(20)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_pinc(cfg_pinc),
    .cfg_poff(cfg_poff), .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .run_en(run_en),
    .phase_in_0(phase_in_0), .phase_in_1(phase_in_1), .phase_in_2(phase_in_2),
    .phase_in_3(phase_in_3), .phase_valid(phase_valid), .ch_index(ch_index),
`ifdef DDC_SCHED_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  assign lane[0] = phase_in_0;
  assign lane[1] = phase_in_1;
  assign lane[2] = phase_in_2;
  assign lane[3] = phase_in_3;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // lane k of a channel: offset poff + k*pinc and increment 4*pinc, both mod 2^20
  function automatic logic [47:0] exp_word(input logic [19:0] p, input logic [19:0] o, input int k);
    longint m, offv, incv;
    m = longint'(1) << 20;
    offv = (longint'(o) + longint'(k) * longint'(p)) % m;
    incv = (longint'(4) * longint'(p)) % m;
    return 48'(offv * (longint'(1) << 24) + incv);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [19:0] p, input logic [19:0] o);
    cfg_wr = 1; cfg_addr = AW'(a); cfg_pinc = p; cfg_poff = o;
    tick();
    cfg_wr = 0;
  endtask

  task automatic randomize_bank();
    for (int i = 0; i < N; i++) begin
      sp[i] = 20'($urandom);
      so[i] = 20'($urandom);
      wr(i, sp[i], so[i]);
    end
  endtask

  task automatic commit_wait(output bit ok);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    for (int n = 0; n < 4 && !cfg_ready; n++) tick();
    ok = cfg_ready;
    ap = sp;
    ao = so;
  endtask

  task automatic start_run(output bit ok);
    ok = 0;
    run_en = 1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (phase_valid && frame_start) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic stop_run(output bit ok);
    ok = 0;
    run_en = 0;
    for (int n = 0; n < 2 * N + 4; n++) begin
      tick();
      if (!phase_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    for (int r = 0; r < 2; r++) begin
      tests++;
      if ({phase_valid, frame_start, ch_index, cfg_ready} !== {2'b00, 2'b00, 1'b1}) begin
        fails++;
        $display("FAIL reset_ctl r=%0d got v=%b fs=%b ch=%0d rdy=%b want 0 0 0 1", r, phase_valid, frame_start, ch_index, cfg_ready);
      end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (lane[k] !== 48'h0) begin
          fails++;
          $display("FAIL reset_lane%0d got %h want 0", k, lane[k]);
        end
      end
      rst = 0;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      sp[i] = 0; so[i] = 0; ap[i] = 0; ao[i] = 0;
    end
  endtask

  task automatic test_first_beat();
    bit ok;
    logic [47:0] want [4];
    want[0] = 48'h0000_1000_0400;
    want[1] = 48'h0001_1000_0400;
    want[3] = 48'h0003_1000_0400;
    sp[0] = 20'h00100; so[0] = 20'h00010;
    wr(0, sp[0], so[0]);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL fb_pending cfg_ready=%b want 0", cfg_ready);
    end
    for (int n = 0; n < 2 && !cfg_ready; n++) tick();
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL fb_ready cfg_ready=%b want 1 within 2 cycles", cfg_ready);
    end
    ap = sp; ao = so;
    start_run(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL fb_start no first beat got v=%b fs=%b want 1 1", phase_valid, frame_start);
    end
    tests++;
    if (ch_index !== 0 || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL fb_ctl got ch=%0d fs=%b want 0 1", ch_index, frame_start);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 2) continue;
      tests++;
      if (lane[k] !== want[k]) begin
        fails++;
        $display("FAIL fb_lane%0d got %h want %h", k, lane[k], want[k]);
      end
    end
    tick();
    tests++;
    if (ch_index !== 1 || phase_valid !== 1'b1 || lane[2] !== 48'h0) begin
      fails++;
      $display("FAIL fb_ch1 got ch=%0d v=%b lane2=%h want 1 1 0", ch_index, phase_valid, lane[2]);
    end
    stop_run(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL fb_stop phase_valid=%b want 0", phase_valid);
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    int nf;
    nf = $urandom_range(2, 4);
    randomize_bank();
    commit_wait(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rf_commit cfg_ready=%b want 1", cfg_ready);
    end
    start_run(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rf_start got v=%b fs=%b want 1 1", phase_valid, frame_start);
    end
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < N; i++) begin
        if (f != 0 || i != 0) tick();
        tests++;
        if (phase_valid !== 1'b1 || ch_index !== AW'(i) || frame_start !== (i == 0)) begin
          fails++;
          $display("FAIL rf_seq f=%0d got v=%b ch=%0d fs=%b want 1 %0d %b", f, phase_valid, ch_index, frame_start, i, i == 0);
        end
`ifdef DDC_SCHED_FRAME_CNT_EN
        if (i == 0) begin
          tests++;
          if (frame_cnt !== 32'(f)) begin
            fails++;
            $display("FAIL rf_frame_cnt got %0d want %0d", frame_cnt, f);
          end
        end
`endif
        for (int k = 0; k < 4; k++) begin
          tests++;
          if (lane[k] !== exp_word(ap[i], ao[i], k)) begin
            fails++;
            $display("FAIL rf_lane f=%0d ch=%0d k=%0d got %h want %h", f, i, k, lane[k], exp_word(ap[i], ao[i], k));
          end
        end
      end
    end
    stop_run(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rf_stop phase_valid=%b want 0", phase_valid);
    end
  endtask

  task automatic test_commit_mid_run();
    bit ok;
    randomize_bank();
    commit_wait(ok);
    start_run(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cm_start got v=%b fs=%b want 1 1", phase_valid, frame_start);
    end
    tick();
    sp[2] = ~ap[2];
    so[2] = 20'($urandom);
    cfg_wr = 1; cfg_addr = 2; cfg_pinc = sp[2]; cfg_poff = so[2]; cfg_commit = 1;
    tick();
    cfg_wr = 0; cfg_commit = 0;
    tests++;
    if (ch_index !== 2 || cfg_ready !== 1'b0 || lane[1] !== exp_word(ap[2], ao[2], 1)) begin
      fails++;
      $display("FAIL cm_old_ch2 got ch=%0d rdy=%b lane1=%h want 2 0 %h", ch_index, cfg_ready, lane[1], exp_word(ap[2], ao[2], 1));
    end
    tick();
    tests++;
    if (ch_index !== 3 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL cm_wrap got ch=%0d rdy=%b want 3 1", ch_index, cfg_ready);
    end
    ap = sp; ao = so;
    for (int i = 0; i < N; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (phase_valid !== 1'b1 || ch_index !== AW'(i) || lane[k] !== exp_word(ap[i], ao[i], k)) begin
          fails++;
          $display("FAIL cm_new ch=%0d k=%0d got v=%b ch=%0d %h want 1 %h", i, k, phase_valid, ch_index, lane[k], exp_word(ap[i], ao[i], k));
        end
      end
    end
    stop_run(ok);
  endtask

  task automatic test_wrap_arith();
    bit ok;
    sp[1] = 20'h7FFFF; so[1] = 20'hFFFFF;
    wr(1, sp[1], so[1]);
    commit_wait(ok);
    start_run(ok);
    tick();
    tests++;
    if (ch_index !== 1 || lane[0] !== {4'h0, 20'hFFFFF, 4'h0, 20'hFFFFC}) begin
      fails++;
      $display("FAIL wa_lane0 got ch=%0d %h want 1 %h", ch_index, lane[0], {4'h0, 20'hFFFFF, 4'h0, 20'hFFFFC});
    end
    tests++;
    if (lane[1] !== {4'h0, 20'h7FFFE, 4'h0, 20'hFFFFC}) begin
      fails++;
      $display("FAIL wa_lane1 got %h want %h", lane[1], {4'h0, 20'h7FFFE, 4'h0, 20'hFFFFC});
    end
    tests++;
    if (lane[3] !== {4'h0, 20'h7FFFC, 4'h0, 20'hFFFFC}) begin
      fails++;
      $display("FAIL wa_lane3 got %h want %h", lane[3], {4'h0, 20'h7FFFC, 4'h0, 20'hFFFFC});
    end
    tests++;
    if (lane[2] !== exp_word(sp[1], so[1], 2)) begin
      fails++;
      $display("FAIL wa_lane2 got %h want %h", lane[2], exp_word(sp[1], so[1], 2));
    end
    stop_run(ok);
  endtask

  task automatic test_dropped_writes();
    bit ok;
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    wr(0, ~sp[0], ~so[0]);
    ap = sp; ao = so;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL dw_ready cfg_ready=%b want 1", cfg_ready);
    end
    commit_wait(ok);
    start_run(ok);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ch_index !== 0 || lane[k] !== exp_word(ap[0], ao[0], k)) begin
        fails++;
        $display("FAIL dw_ch0 k=%0d got ch=%0d %h want 0 %h", k, ch_index, lane[k], exp_word(ap[0], ao[0], k));
      end
    end
    stop_run(ok);
  endtask

  task automatic test_stop();
    bit ok;
    randomize_bank();
    commit_wait(ok);
    start_run(ok);
    tick();
    run_en = 0;
    for (int i = 2; i < N; i++) begin
      tick();
      tests++;
      if (phase_valid !== 1'b1 || ch_index !== AW'(i) || lane[3] !== exp_word(ap[i], ao[i], 3)) begin
        fails++;
        $display("FAIL st_tail got v=%b ch=%0d %h want 1 %0d %h", phase_valid, ch_index, lane[3], i, exp_word(ap[i], ao[i], 3));
      end
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      tests++;
      if (phase_valid !== 1'b0) begin
        fails++;
        $display("FAIL st_idle n=%0d phase_valid=%b want 0", n, phase_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    randomize_bank();
    commit_wait(ok);
    start_run(ok);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    tests++;
    if (cfg_ready !== 1'b0 || ch_index !== 1) begin
      fails++;
      $display("FAIL ar_pre got rdy=%b ch=%0d want 0 1", cfg_ready, ch_index);
    end
    @(negedge clk);
    #1 rst = 1;
    #1;
    tests++;
    if ({phase_valid, frame_start, ch_index, cfg_ready} !== {2'b00, 2'b00, 1'b1}) begin
      fails++;
      $display("FAIL ar_ctl got v=%b fs=%b ch=%0d rdy=%b want 0 0 0 1", phase_valid, frame_start, ch_index, cfg_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (lane[k] !== 48'h0) begin
        fails++;
        $display("FAIL ar_lane%0d got %h want 0", k, lane[k]);
      end
    end
    run_en = 0;
    tick();
    rst = 0;
    tick();
    tests++;
    if (phase_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL ar_after got v=%b rdy=%b want 0 1", phase_valid, cfg_ready);
    end
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_random_frames();
    test_commit_mid_run();
    test_wrap_arith();
    test_dropped_writes();
    test_stop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
